// File: rtl/rv32i_dmem_arbiter.sv
// Two-requester arbiter/sequencer for the data port of a synchronous RAM.
// Latency: grant, RAM controls and err are combinational in the grant cycle; rvalid_o/rdata_o are registered RD_LATENCY+1 edges after a read grant.
// Backpressure: requests are level signals held until gnt_o; no grants are issued while a read waits for RAM data.
//
// Ports:
//   clk, reset_n                 clock and asynchronous active-low reset
//   req_i, we_i                  per-requester request level and write/read select
//   addrN_i, widthN_i, signN_i   byte address, access width (00 byte, 01 half, 10 word), sign-extend flag
//   wdataN_i                     right-justified store data
//   gnt_o, err_o                 one-hot grant pulse; one-hot misalign/illegal pulse with the grant
//   rvalid_o, rdata_o            one-hot load-valid pulse and the aligned, extended load data
//   d_addr, d_we, d_be, d_wdata  RAM word address, write enable, byte enables, lane-shifted store data
//   d_rdata                      RAM read data
module rv32i_dmem_arbiter #(
    parameter int FIXED_PRIO = 0,  // 0: round-robin on ties, 1: requester 0 always wins ties
    parameter int RD_LATENCY = 1   // RAM read latency in cycles, 1 or 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  req_i,
    input  logic [1:0]  we_i,
    input  logic [31:0] addr0_i,
    input  logic [31:0] addr1_i,
    input  logic [1:0]  width0_i,
    input  logic [1:0]  width1_i,
    input  logic        sign0_i,
    input  logic        sign1_i,
    input  logic [31:0] wdata0_i,
    input  logic [31:0] wdata1_i,
    output logic [1:0]  gnt_o,
    output logic [1:0]  rvalid_o,
    output logic [1:0]  err_o,
    output logic [31:0] rdata_o,
    output logic [29:0] d_addr,
    output logic        d_we,
    output logic [3:0]  d_be,
    output logic [31:0] d_wdata,
    input  logic [31:0] d_rdata
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        RD_DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        last_q, last_d;      // requester granted most recently
    logic        w_q, w_d;            // requester owning the outstanding read
    logic [1:0]  off_q, off_d;
    logic [1:0]  width_q, width_d;
    logic        sign_q, sign_d;
    logic [1:0]  cnt_q, cnt_d;        // remaining extra wait cycles for the RAM
    logic [1:0]  rvalid_q, rvalid_d;
    logic [31:0] rdata_q, rdata_d;

    // ------------------------------------------------------------------
    // Arbitration. Gating with reset_n keeps every combinational output
    // low while reset is asserted, even if a requester holds req high.
    // ------------------------------------------------------------------
    logic       arb_en;
    logic [1:0] req_eff;
    logic       win;

    assign arb_en  = reset_n && (state_q != RD_WAIT);
    assign req_eff = req_i & {2{arb_en}};

    always_comb begin
        win = 1'b0;
        if (req_eff == 2'b10) begin
            win = 1'b1;
        end else if (req_eff == 2'b11) begin
            win = (FIXED_PRIO != 0) ? 1'b0 : ~last_q;
        end
    end

    // Selected request fields
    logic [31:0] w_addr;
    logic [1:0]  w_width;
    logic        w_sign;
    logic [31:0] w_wdata;
    logic        w_we;
    logic [1:0]  w_off;

    assign w_addr  = win ? addr1_i  : addr0_i;
    assign w_width = win ? width1_i : width0_i;
    assign w_sign  = win ? sign1_i  : sign0_i;
    assign w_wdata = win ? wdata1_i : wdata0_i;
    assign w_we    = we_i[win];
    assign w_off   = w_addr[1:0];

    // Natural alignment check and byte-lane mask of the winning request
    logic       w_legal;
    logic [3:0] w_be;

    always_comb begin
        w_legal = 1'b0;
        w_be    = 4'b0000;
        case (w_width)
            2'b00: begin
                w_legal = 1'b1;
                w_be    = 4'b0001 << w_off;
            end
            2'b01: begin
                w_legal = ~w_off[0];
                w_be    = 4'b0011 << w_off;
            end
            2'b10: begin
                w_legal = (w_off == 2'b00);
                w_be    = 4'b1111;
            end
            default: begin
                w_legal = 1'b0;
                w_be    = 4'b0000;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Load alignment and extension, using the fields latched at grant.
    // ------------------------------------------------------------------
    logic [31:0] rd_shift;
    logic [31:0] rd_ext;

    assign rd_shift = d_rdata >> {off_q, 3'b000};

    always_comb begin
        rd_ext = rd_shift;
        case (width_q)
            2'b00:   rd_ext = {{24{sign_q & rd_shift[7]}},  rd_shift[7:0]};
            2'b01:   rd_ext = {{16{sign_q & rd_shift[15]}}, rd_shift[15:0]};
            default: rd_ext = rd_shift;
        endcase
    end

    // ------------------------------------------------------------------
    // Next-state and outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        w_d      = w_q;
        off_d    = off_q;
        width_d  = width_q;
        sign_d   = sign_q;
        cnt_d    = cnt_q;
        rvalid_d = 2'b00;
        rdata_d  = rdata_q;
        gnt_o    = 2'b00;
        err_o    = 2'b00;
        d_addr   = '0;
        d_we     = 1'b0;
        d_be     = 4'b0000;
        d_wdata  = '0;

        case (state_q)
            // RD_DONE only differs from IDLE by the registered rvalid pulse,
            // so a new access can be granted in the same cycle.
            IDLE, RD_DONE: begin
                state_d = IDLE;
                if (|req_eff) begin
                    gnt_o[win] = 1'b1;
                    last_d     = win;
                    if (!w_legal) begin
                        err_o[win] = 1'b1;
                    end else begin
                        d_addr = w_addr[31:2];
                        d_be   = w_be;
                        if (w_we) begin
                            d_we    = 1'b1;
                            d_wdata = w_wdata << {w_off, 3'b000};
                        end else begin
                            state_d = RD_WAIT;
                            w_d     = win;
                            off_d   = w_off;
                            width_d = w_width;
                            sign_d  = w_sign;
                            cnt_d   = 2'(RD_LATENCY - 1);
                        end
                    end
                end
            end

            // RAM data is valid on d_rdata in the last wait cycle; it is
            // aligned and registered at that cycle's closing edge.
            RD_WAIT: begin
                if (cnt_q == 2'd0) begin
                    state_d       = RD_DONE;
                    rvalid_d[w_q] = 1'b1;
                    rdata_d       = rd_ext;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            last_q   <= 1'b1;
            w_q      <= 1'b0;
            off_q    <= 2'b00;
            width_q  <= 2'b00;
            sign_q   <= 1'b0;
            cnt_q    <= 2'd0;
            rvalid_q <= 2'b00;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            w_q      <= w_d;
            off_q    <= off_d;
            width_q  <= width_d;
            sign_q   <= sign_d;
            cnt_q    <= cnt_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
        end
    end

    assign rvalid_o = rvalid_q;
    assign rdata_o  = rdata_q;

endmodule

// File: tb/tb_rv32i_dmem_arbiter.sv
// Bench for rv32i_dmem_arbiter: directed cases plus randomized single-requester traffic.
// A behavioural RAM drives d_rdata; expected results come from a byte-array memory model.
module tb_rv32i_dmem_arbiter;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  req_i = '0;
    logic [1:0]  we_i = '0;
    logic [31:0] addr0_i = '0, addr1_i = '0;
    logic [1:0]  width0_i = '0, width1_i = '0;
    logic        sign0_i = 1'b0, sign1_i = 1'b0;
    logic [31:0] wdata0_i = '0, wdata1_i = '0;
    logic [1:0]  gnt_o, rvalid_o, err_o;
    logic [31:0] rdata_o;
    logic [29:0] d_addr;
    logic        d_we;
    logic [3:0]  d_be;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;

    // fixed-priority instance: only its grants are observed
    logic [1:0]  fp_gnt, fp_rvalid, fp_err;
    logic [31:0] fp_rdata, fp_wdata;
    logic [29:0] fp_addr;
    logic        fp_we;
    logic [3:0]  fp_be;

    always #5 clk = ~clk;

    rv32i_dmem_arbiter #(.FIXED_PRIO(0), .RD_LATENCY(1)) dut (
        .clk(clk), .reset_n(reset_n), .req_i(req_i), .we_i(we_i),
        .addr0_i(addr0_i), .addr1_i(addr1_i), .width0_i(width0_i), .width1_i(width1_i),
        .sign0_i(sign0_i), .sign1_i(sign1_i), .wdata0_i(wdata0_i), .wdata1_i(wdata1_i),
        .gnt_o(gnt_o), .rvalid_o(rvalid_o), .err_o(err_o), .rdata_o(rdata_o),
        .d_addr(d_addr), .d_we(d_we), .d_be(d_be), .d_wdata(d_wdata), .d_rdata(d_rdata)
    );

    rv32i_dmem_arbiter #(.FIXED_PRIO(1), .RD_LATENCY(1)) dut_fp (
        .clk(clk), .reset_n(reset_n), .req_i(req_i), .we_i(we_i),
        .addr0_i(addr0_i), .addr1_i(addr1_i), .width0_i(width0_i), .width1_i(width1_i),
        .sign0_i(sign0_i), .sign1_i(sign1_i), .wdata0_i(wdata0_i), .wdata1_i(wdata1_i),
        .gnt_o(fp_gnt), .rvalid_o(fp_rvalid), .err_o(fp_err), .rdata_o(fp_rdata),
        .d_addr(fp_addr), .d_we(fp_we), .d_be(fp_be), .d_wdata(fp_wdata), .d_rdata(d_rdata)
    );

    // Behavioural synchronous RAM, one-cycle read latency, 256 words
    logic [31:0] ram [0:255];
    always @(posedge clk) begin
        if (d_we) begin
            for (int i = 0; i < 4; i++)
                if (d_be[i]) ram[d_addr[7:0]][8*i +: 8] <= d_wdata[8*i +: 8];
        end
        d_rdata <= ram[d_addr[7:0]];
    end

    // Reference memory as plain bytes
    logic [7:0] model_mem [0:1023];

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One access from requester r with no competition; checks grant-cycle
    // controls, the write pulse width, load latency/data and rdata hold.
    task automatic do_txn(input int r, input bit we, input logic [31:0] addr,
                          input logic [1:0] width, input bit sgn, input logic [31:0] wd,
                          output logic [31:0] got);
        bit          granted;
        bit          legal;
        int          size;
        int          off;
        int          a;
        logic [31:0] be_exp;
        logic [31:0] exp_ld;
        got = '0;
        if (r == 0) begin
            addr0_i = addr; width0_i = width; sign0_i = sgn; wdata0_i = wd;
        end else begin
            addr1_i = addr; width1_i = width; sign1_i = sgn; wdata1_i = wd;
        end
        we_i[r]  = we;
        req_i[r] = 1'b1;
        granted  = 1'b0;
        for (int c = 0; c < 20 && !granted; c++) begin
            @(negedge clk);
            if (gnt_o != 2'b00) granted = 1'b1;
        end
        if (!granted) begin
            chk("gnt_timeout", 32'd0, 32'd1);
            req_i[r] = 1'b0;
            return;
        end
        size   = 1 << width;
        off    = int'(addr[1:0]);
        a      = int'(addr[9:0]);
        legal  = (width != 2'b11) && ((off % size) == 0);
        be_exp = ((32'd1 << size) - 1) << off;
        chk("gnt", gnt_o, 32'd1 << r);
        chk("err", err_o, legal ? 32'd0 : (32'd1 << r));
        chk("d_we", d_we, (legal && we) ? 32'd1 : 32'd0);
        chk("d_be", d_be, legal ? be_exp : 32'd0);
        if (legal) chk("d_addr", d_addr, addr >> 2);
        if (legal && we) chk("d_wdata", d_wdata, wd << (8 * off));
        @(posedge clk);
        #1 req_i[r] = 1'b0;
        if (legal && we)
            for (int i = 0; i < size; i++) model_mem[a + i] = wd[8*i +: 8];
        @(negedge clk);
        chk("we_pulse", d_we, 32'd0);
        chk("rvalid_early", rvalid_o, 32'd0);
        @(negedge clk);
        if (legal && !we) begin
            exp_ld = '0;
            for (int i = 0; i < size; i++) exp_ld = exp_ld | (32'(model_mem[a + i]) << (8 * i));
            if (sgn && size < 4 && exp_ld[8*size-1])
                exp_ld = exp_ld | ~((32'd1 << (8 * size)) - 1);
            chk("rvalid", rvalid_o, 32'd1 << r);
            chk("rdata", rdata_o, exp_ld);
            got = rdata_o;
            @(negedge clk);
            chk("rvalid_pulse", rvalid_o, 32'd0);
            chk("rdata_hold", rdata_o, exp_ld);
        end else begin
            chk("no_rvalid", rvalid_o, 32'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] got;
        int          n_rr, n_fp;
        for (int i = 0; i < 256; i++) ram[i] = '0;
        for (int i = 0; i < 1024; i++) model_mem[i] = '0;
        req_i = 2'b01;  // a pending request must not leak through reset
        #12;
        chk("rst_gnt", gnt_o, 0);
        chk("rst_rvalid", rvalid_o, 0);
        chk("rst_err", err_o, 0);
        chk("rst_rdata", rdata_o, 0);
        chk("rst_d_we", d_we, 0);
        chk("rst_d_be", d_be, 0);
        req_i = 2'b00;
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed cases
        do_txn(0, 1'b1, 32'h50, 2'b00, 1'b0, 32'h80, got);
        do_txn(0, 1'b1, 32'h53, 2'b00, 1'b0, 32'h50, got);
        do_txn(0, 1'b0, 32'h53, 2'b00, 1'b0, 32'h0, got);
        chk("dir_byte_u", got, 32'h00000050);
        do_txn(0, 1'b1, 32'h60, 2'b10, 1'b0, 32'h12345678, got);
        do_txn(0, 1'b1, 32'h62, 2'b01, 1'b1, 32'hFFFB, got);
        do_txn(0, 1'b0, 32'h62, 2'b01, 1'b1, 32'h0, got);
        chk("dir_half_s", got, 32'hFFFFFFFB);
        do_txn(0, 1'b0, 32'h60, 2'b10, 1'b0, 32'h0, got);
        chk("dir_word", got, 32'hFFFB5678);
        do_txn(0, 1'b0, 32'h61, 2'b10, 1'b0, 32'h0, got);
        do_txn(0, 1'b0, 32'h60, 2'b11, 1'b0, 32'h0, got);
        do_txn(1, 1'b0, 32'h63, 2'b01, 1'b0, 32'h0, got);
        do_txn(1, 1'b0, 32'h53, 2'b00, 1'b1, 32'h0, got);
        chk("dir_byte_s1", got, 32'h00000050);

        // Contention from a fresh reset: round-robin alternates, fixed priority sticks to 0
        reset_n = 1'b0;
        #2;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        addr0_i = 32'h0; width0_i = 2'b10; sign0_i = 1'b0;
        addr1_i = 32'h4; width1_i = 2'b10; sign1_i = 1'b0;
        we_i = 2'b00;
        req_i = 2'b11;
        n_rr = 0;
        n_fp = 0;
        for (int c = 0; c < 40 && (n_rr < 4 || n_fp < 4); c++) begin
            @(negedge clk);
            if (gnt_o != 2'b00) begin
                chk("rr_gnt", gnt_o, (n_rr % 2 == 0) ? 32'd1 : 32'd2);
                n_rr++;
            end
            if (fp_gnt != 2'b00) begin
                chk("fp_gnt", fp_gnt, 32'd1);
                n_fp++;
            end
        end
        chk("rr_count", (n_rr >= 4) ? 32'd1 : 32'd0, 32'd1);
        chk("fp_count", (n_fp >= 4) ? 32'd1 : 32'd0, 32'd1);
        @(posedge clk);
        #1 req_i = 2'b00;
        repeat (4) @(posedge clk);
        #1;

        // Reset while a read waits for RAM data
        do_txn(0, 1'b0, 32'h60, 2'b10, 1'b0, 32'h0, got);
        addr0_i = 32'h60; width0_i = 2'b10; we_i[0] = 1'b0; req_i[0] = 1'b1;
        n_rr = 0;
        for (int c = 0; c < 20 && n_rr == 0; c++) begin
            @(negedge clk);
            if (gnt_o != 2'b00) n_rr = 1;
        end
        chk("mid_gnt_seen", n_rr, 1);
        @(posedge clk);
        #1 req_i = 2'b00;
        #1 reset_n = 1'b0;
        #1;
        chk("mid_rst_rvalid", rvalid_o, 0);
        chk("mid_rst_rdata", rdata_o, 0);
        chk("mid_rst_gnt", gnt_o, 0);
        chk("mid_rst_d_be", d_be, 0);
        @(negedge clk);
        reset_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("mid_rst_no_rvalid", rvalid_o, 0);
        end
        @(posedge clk);
        #1;
        do_txn(0, 1'b0, 32'h60, 2'b10, 1'b0, 32'h0, got);
        chk("post_rst_word", got, 32'hFFFB5678);

        // Randomized single-requester traffic
        for (int t = 0; t < 80; t++) begin
            int          r;
            bit          we;
            logic [31:0] addr;
            logic [1:0]  width;
            bit          sgn;
            logic [31:0] wd;
            r     = int'($urandom_range(0, 1));
            we    = 1'($urandom_range(0, 1));
            addr  = 32'($urandom_range(0, 255));
            width = 2'($urandom_range(0, 3));
            sgn   = 1'($urandom_range(0, 1));
            wd    = $urandom;
            do_txn(r, we, addr, width, sgn, wd, got);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rv32i_dmem_arbiter.md
Name: rv32i_dmem_arbiter

Overview:
- Two-requester arbiter and sequencer for the data port of the synchronous dual-port RAM.
- Requester 0 is the core load/store path; requester 1 is the loader/debug path.
- Grants one access at a time and generates word address, byte enables and lane-shifted write data.
- Captures the 1-cycle-latency read data, then aligns and sign/zero-extends it per the granted request.
- Flags misaligned or illegal-width accesses without touching the RAM.

Parameters:
- FIXED_PRIO, 0: 0 = round-robin between requesters; 1 = requester 0 always wins ties.
- RD_LATENCY, 1: RAM read latency in cycles; legal values are 1 and 2.

Ports:
- clk  in  1  system clock, all state on rising edge
- reset_n  in  1  asynchronous active-low reset
- req_i  in  2  per-requester access request, level, held until gnt
- we_i  in  2  per-requester write (1) / read (0)
- addr0_i, addr1_i  in  32  byte address
- width0_i, width1_i  in  2  00 byte, 01 half, 10 word, 11 illegal
- sign0_i, sign1_i  in  1  1 = sign-extend load
- wdata0_i, wdata1_i  in  32  store data, right-justified
- gnt_o  out  2  one-hot grant pulse, 1 cycle
- rvalid_o  out  2  one-hot read-data-valid pulse
- err_o  out  2  one-hot misalign/illegal pulse, coincident with gnt
- rdata_o  out  32  aligned, extended load data; valid when rvalid_o != 0
- d_addr  out  30  RAM word address = addr[31:2] of the granted request
- d_we  out  1  RAM write enable
- d_be  out  4  RAM byte enables
- d_wdata  out  32  lane-shifted store data
- d_rdata  in  32  RAM read data

Behaviour:
- Reset (async, reset_n=0):
  - gnt_o=0, rvalid_o=0, err_o=0, rdata_o=0, d_we=0, d_be=0.
  - State=IDLE; last-grant pointer=1, so requester 0 wins the first tie.
- States:
  - IDLE:
    - If no req, stay in IDLE and drive d_we=0.
    - Otherwise choose the winner: single requester wins; on a tie, round-robin picks the requester that is not the last grant, or requester 0 if FIXED_PRIO=1.
    - Assert gnt_o[w] combinationally this cycle and update the pointer to w.
  - Legality check for winner w:
    - byte: any offset.
    - half: offset in {0,2}.
    - word: offset 0.
    - width 11: illegal.
    - On an illegal access: err_o[w]=1 with gnt; d_we=0, d_be=0; no rvalid; stay IDLE.
  - Legal write:
    - d_we=1.
    - d_be: byte = 0001<<off, half = 0011<<off, word = 1111.
    - d_wdata = wdata << (8*off).
    - Completes in the grant cycle; stay IDLE.
  - Legal read:
    - d_we=0; d_be as for writes.
    - Latch w, off, width and sign; go to RD_WAIT.
  - RD_WAIT:
    - Counts RD_LATENCY-1 further cycles.
    - No grants are issued and d_we is forced to 0.
    - Then go to RD_DONE.
  - RD_DONE:
    - Registered outputs: rvalid_o[w]=1 and rdata_o = (d_rdata >> 8*off), masked to width, extended per sign.
    - Arbitration for the next access happens in the same cycle, so back-to-back reads sustain 1 access per RD_LATENCY+1 cycles.
- Read latency: rvalid_o follows the read grant by exactly RD_LATENCY+1 rising edges. RD_LATENCY=1 gives a 2-cycle latency.
- Extension:
  - Byte signed replicates bit 7; half signed replicates bit 15.
  - Unsigned accesses zero-fill.
  - Word loads are never extended.
- rdata_o holds its last value when rvalid_o=0.
- Requesters must keep addr/width/sign/wdata stable while req is high and not granted. A request dropped before grant is simply not served.
- Simultaneous events:
  - A request arriving during RD_WAIT waits.
  - A requester with rvalid in the current cycle may be granted again in that same cycle, subject to round-robin.
- Reset mid-read discards the pending read: no rvalid is issued after reset deasserts.

Test Plan:
- Write byte: req0, addr 0x50, width 00, wdata 0x80 -> gnt_o=01, d_addr=0x14, d_be=0001, d_wdata=0x00000080, d_we=1 for 1 cycle.
- Write byte at offset 3: addr 0x53, wdata 0x50 -> d_be=1000, d_wdata=0x50000000. Then read byte unsigned at 0x53 -> rvalid_o=01 2 cycles after gnt, rdata_o=0x00000050.
- Word write 0x12345678 at 0x60, then signed half write 0xFFFB at 0x62, then signed half read at 0x62 -> rdata_o=0xFFFFFFFB. Word read at 0x60 -> 0xFFFB5678.
- Misaligned: word read at 0x61 -> gnt_o=01 and err_o=01 same cycle, d_be=0, d_we=0, no rvalid. Width 11 -> same response.
- Contention: req_i=11 held, all reads, FIXED_PRIO=0 -> grants alternate 01,10,01,10 from reset. With FIXED_PRIO=1 -> every grant goes to 01 until req0 drops.
- Reset mid-read: drop reset_n in RD_WAIT -> all outputs 0 asynchronously; after release, no rvalid; next req0 granted from IDLE.
